// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller: IEEE 1149.1 TAP state machine with IR/DR strobes and gated
// test clocks. Optional `TAP_STATE_OUT_EN` exposes the raw state register.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tap_controller (
  input  logic       tck,
  input  logic       tl_reset,
  input  logic       tms,
  output logic       logic_reset_n,
  output logic       captureIR,
  output logic       shiftIR,
  output logic       updateIR,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       updateDR,
  output logic       tck_ir,
  output logic       tck_dr,
  output logic       select_ir,
`ifdef TAP_STATE_OUT_EN
  output logic [3:0] tap_state,
`endif
  output logic       tdo_en
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } state_t;

  state_t state;
  state_t state_next;
  logic   en_ir;
  logic   en_dr;

  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) state <= TLR;
    else           state <= state_next;
  end

  always_comb begin
    state_next = TLR;
    captureIR  = 1'b0;
    shiftIR    = 1'b0;
    captureDR  = 1'b0;
    shiftDR    = 1'b0;
    select_ir  = 1'b0;
    case (state)
      TLR:      state_next = tms ? TLR    : RTI;
      RTI:      state_next = tms ? SEL_DR : RTI;
      SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
      SH_DR:    state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_next = tms ? SEL_DR : RTI;
      SEL_IR:   state_next = tms ? TLR    : CAP_IR;
      CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
      SH_IR:    state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_next = tms ? SEL_DR : RTI;
      default:  state_next = TLR;
    endcase
    captureIR = (state == CAP_IR);
    shiftIR   = (state == SH_IR);
    captureDR = (state == CAP_DR);
    shiftDR   = (state == SH_DR);
    select_ir = (state == SEL_IR) || (state == CAP_IR) || (state == SH_IR) ||
                (state == EX1_IR) || (state == PAUSE_IR) || (state == EX2_IR) ||
                (state == UPD_IR);
  end

  // Enables change only while tck is low, so the AND gates below cannot glitch.
  always_ff @(negedge tck or negedge tl_reset) begin
    if (!tl_reset) begin
      logic_reset_n <= 1'b0;
      updateIR      <= 1'b0;
      updateDR      <= 1'b0;
      en_ir         <= 1'b0;
      en_dr         <= 1'b0;
      tdo_en        <= 1'b0;
    end else begin
      logic_reset_n <= (state != TLR);
      updateIR      <= (state == UPD_IR);
      updateDR      <= (state == UPD_DR);
      en_ir         <= captureIR | shiftIR;
      en_dr         <= captureDR | shiftDR;
      tdo_en        <= shiftIR | shiftDR;
    end
  end

  assign tck_ir = tck & en_ir;
  assign tck_dr = tck & en_dr;

`ifdef TAP_STATE_OUT_EN
  assign tap_state = state;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_tap_controller: randomized TMS walk against a table-driven TAP model,
// plus directed IR/DR scans and reset scenarios with literal expectations.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tap_controller;

  logic tck = 1'b0;
  logic tl_reset = 1'b0;
  logic tms = 1'b1;
  logic logic_reset_n, captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR;
  logic tck_ir, tck_dr, select_ir, tdo_en;
`ifdef TAP_STATE_OUT_EN
  logic [3:0] tap_state;
`endif

  tap_controller dut (
    .tck(tck), .tl_reset(tl_reset), .tms(tms),
    .logic_reset_n(logic_reset_n),
    .captureIR(captureIR), .shiftIR(shiftIR), .updateIR(updateIR),
    .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
    .tck_ir(tck_ir), .tck_dr(tck_dr), .select_ir(select_ir),
`ifdef TAP_STATE_OUT_EN
    .tap_state(tap_state),
`endif
    .tdo_en(tdo_en)
  );

  always #5 tck = ~tck;

  // Successor tables indexed by state code (0..15), straight from the TAP diagram.
  int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
  localparam logic [15:0] IR_COL = 16'h6F10;

  int ms = 15;
  bit m_lrn = 0, m_uir = 0, m_udr = 0, m_enir = 0, m_endr = 0, m_tdo = 0;
  bit [31:0] cov = '0;
  bit chk_en = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge tck) begin
    if (tl_reset === 1'b1) begin
      cov[ms * 2 + int'(tms)] = 1'b1;
      ms = tms ? nxt1[ms] : nxt0[ms];
    end
  end

  always @(negedge tck) begin
    if (tl_reset === 1'b1) begin
      m_lrn  = (ms != 15);
      m_uir  = (ms == 13);
      m_udr  = (ms == 5);
      m_enir = (ms == 14) || (ms == 10);
      m_endr = (ms == 6) || (ms == 2);
      m_tdo  = (ms == 10) || (ms == 2);
    end
  end

  always @(negedge tl_reset) begin
    ms = 15;
    m_lrn = 0; m_uir = 0; m_udr = 0; m_enir = 0; m_endr = 0; m_tdo = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every tck edge and reset edge, 1 time unit later.
  logic [10:0] dut_vec, exp_vec;
  always begin
    @(tck or tl_reset);
    #1;
    if (chk_en) begin
      dut_vec = {logic_reset_n, captureIR, shiftIR, updateIR, captureDR, shiftDR,
                 updateDR, tck_ir, tck_dr, select_ir, tdo_en};
      exp_vec = {m_lrn, ms == 14, ms == 10, m_uir, ms == 6, ms == 2, m_udr,
                 tck & m_enir, tck & m_endr, IR_COL[ms], m_tdo};
      chk("outputs", 32'(dut_vec), 32'(exp_vec));
`ifdef TAP_STATE_OUT_EN
      chk("tap_state", 32'(tap_state), 32'(ms));
`endif
    end
  end

  int n_tckir = 0, n_tckdr = 0, n_uir = 0, n_udr = 0;
  int n_capir = 0, n_shir = 0, n_shdr = 0, n_selir = 0, n_tdo = 0;
  always @(posedge tck_ir) n_tckir++;
  always @(posedge tck_dr) n_tckdr++;
  always @(posedge updateIR) n_uir++;
  always @(posedge updateDR) n_udr++;
  always @(negedge tck) begin
    if (captureIR) n_capir++;
    if (shiftIR)   n_shir++;
    if (shiftDR)   n_shdr++;
    if (select_ir) n_selir++;
  end
  always @(posedge tck) if (tdo_en) n_tdo++;

  task automatic clear_counts();
    n_tckir = 0; n_tckdr = 0; n_uir = 0; n_udr = 0;
    n_capir = 0; n_shir = 0; n_shdr = 0; n_selir = 0; n_tdo = 0;
  endtask

  // Present t before the next rising edge; return 2 units after that edge.
  task automatic step(input bit t);
    @(negedge tck);
    tms = t;
    @(posedge tck);
    #2;
  endtask

  task automatic seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge tck);
    #2;
    chk("reset_lrn", 32'(logic_reset_n), 0);
    chk("reset_strobes", 32'({captureIR, shiftIR, captureDR, shiftDR, select_ir,
        updateIR, updateDR, tck_ir, tck_dr, tdo_en}), 0);
    chk_en = 1;
    tl_reset = 1'b1;

    step(1'b0);
    chk("rti_lrn_before_negedge", 32'(logic_reset_n), 0);
    @(negedge tck); #2;
    chk("rti_lrn_after_negedge", 32'(logic_reset_n), 1);

    // IR scan: SelDR, SelIR, CapIR, ShIR x4, Ex1IR, UpdIR, RTI
    clear_counts();
    seq(16'b1100000110, 10);
    chk("ir_capture_periods", n_capir, 1);
    chk("ir_shift_periods", n_shir, 4);
    chk("ir_tck_ir_edges", n_tckir, 5);
    chk("ir_update_pulses", n_uir, 1);
    chk("ir_tdo_en_periods", n_tdo, 4);
    chk("ir_no_tck_dr", n_tckdr, 0);

    // DR scan with 3 pause periods, then RTI
    clear_counts();
    seq(16'b100100010110, 12);
    chk("dr_tck_dr_edges", n_tckdr, 3);
    chk("dr_shift_periods", n_shdr, 2);
    chk("dr_update_pulses", n_udr, 1);
    chk("dr_select_ir_zero", n_selir, 0);
    chk("dr_no_tck_ir", n_tckir, 0);

    // Five TMS=1 from Shift-IR lands in Test-Logic-Reset
    seq(16'b1100, 4);
    chk("sync_in_shir", 32'(shiftIR), 1);
    seq(16'b11111, 5);
    chk("sync_lrn_still_high", 32'(logic_reset_n), 1);
    chk("sync_decodes_idle", 32'({captureIR, shiftIR, captureDR, shiftDR, select_ir}), 0);
    @(negedge tck); #2;
    chk("sync_lrn_low", 32'(logic_reset_n), 0);

    // Async reset while in Shift-DR with tck high
    seq(16'b01000, 5);
    chk("async_pre_tck_dr", 32'(tck_dr), 1);
    chk("async_pre_tdo_en", 32'(tdo_en), 1);
    tl_reset = 1'b0;
    #1;
    chk("async_tck_dr", 32'(tck_dr), 0);
    chk("async_tdo_en", 32'(tdo_en), 0);
    chk("async_shiftDR", 32'(shiftDR), 0);
    chk("async_lrn", 32'(logic_reset_n), 0);
    @(negedge tck); #2;
    tl_reset = 1'b1;

    // Random walk with occasional asynchronous resets
    repeat (3000) begin
      if ($urandom_range(63) == 0) begin
        tl_reset = 1'b0;
        @(negedge tck); #2;
        tl_reset = 1'b1;
      end else begin
        step(1'($urandom_range(1)));
      end
    end
    chk("transition_coverage", $countones(cov), 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
